// File: rtl/piso_stream_if.sv
// Load/serial-out bundle for piso_stream. The producer side (word source plus
// shift enable) uses the master modport; the serialiser uses the slave modport.
interface piso_stream_if #(
   parameter int unsigned WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] pin;
   logic             shift_en;
   logic             sout;
   logic             sout_valid;
   logic             last;
   logic             busy;

   modport master (
      output load_valid,
      output pin,
      output shift_en,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  last,
      input  busy
   );

   modport slave (
      input  load_valid,
      input  pin,
      input  shift_en,
      output load_ready,
      output sout,
      output sout_valid,
      output last,
      output busy
   );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake,
// shift stall, selectable bit order and framing outputs. A new word may be
// accepted on the same edge that retires the final bit, so consecutive words
// stream with no gap. The interface WIDTH must match this module's WIDTH.
module piso_stream #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input logic         clk,
   input logic         rst,
   piso_stream_if.slave link
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shifted;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_valid_q, last_q;
   logic             accept;
   logic             next_bit;

   // Ready whenever idle, or when the final bit leaves at this very edge.
   assign link.load_ready = !rst && ((state_q == StIdle) || (last_q && link.shift_en));
   assign accept          = link.load_valid && link.load_ready;

   assign link.sout       = sout_q;
   assign link.sout_valid = sout_valid_q;
   assign link.last       = last_q;
   assign link.busy       = sout_valid_q;

   // Shift toward the output end with zero fill.
   always_comb begin
      sreg_shifted = '0;
      if (MSB_FIRST) begin
         sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
         sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
      end
   end

   // Next-state for state, shift register and bit counter.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               sreg_d  = link.pin;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (link.shift_en) begin
               if (cnt_q == CNT_MAX) begin
                  if (accept) begin
                     sreg_d = link.pin;
                  end else begin
                     sreg_d  = '0;
                     state_d = StIdle;
                  end
                  cnt_d = '0;
               end else begin
                  sreg_d = sreg_shifted;
                  cnt_d  = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bit that will be presented once sreg_d is registered.
   always_comb begin
      next_bit = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
   end

   // State registers plus registered outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         sreg_q       <= '0;
         cnt_q        <= '0;
         sout_q       <= IDLE_LEVEL;
         sout_valid_q <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         cnt_q        <= cnt_d;
         sout_q       <= (state_d == StShift) ? next_bit : IDLE_LEVEL;
         sout_valid_q <= (state_d == StShift);
         last_q       <= (state_d == StShift) && (cnt_d == CNT_MAX);
      end
   end
endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: a per-cycle vector table on a 4-bit MSB-first
// instance, plus hand-written sequences for LSB-first, gap-free back-to-back,
// mid-word reset and a high idle level.
module tb_piso_stream;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   piso_stream_if #(.WIDTH(4)) if_a ();
   piso_stream_if #(.WIDTH(4)) if_b ();
   piso_stream_if #(.WIDTH(8)) if_c ();
   piso_stream_if #(.WIDTH(8)) if_d ();

   piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
      .clk(clk), .rst(rst), .link(if_a)
   );
   piso_stream #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
      .clk(clk), .rst(rst), .link(if_b)
   );
   piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_c (
      .clk(clk), .rst(rst), .link(if_c)
   );
   piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_d (
      .clk(clk), .rst(rst), .link(if_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       lv;
      logic [3:0] pin;
      logic       se;
      logic       sout;
      logic       sv;
      logic       last;
      logic       rdy;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [15:0] b2b;
      logic [7:0]  w81;
      logic [3:0]  wb;
      errors = 0;
      checks = 0;
      b2b = 16'hA53C;
      w81 = 8'h81;
      wb  = 4'b1100;

      //            rst   lv    pin    se   | sout  sv    last  rdy
      vecs[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      if_a.load_valid = 1'b0; if_a.pin = '0; if_a.shift_en = 1'b0;
      if_b.load_valid = 1'b0; if_b.pin = '0; if_b.shift_en = 1'b0;
      if_c.load_valid = 1'b0; if_c.pin = '0; if_c.shift_en = 1'b0;
      if_d.load_valid = 1'b0; if_d.pin = '0; if_d.shift_en = 1'b0;
      repeat (3) @(posedge clk);

      // Table: MSB-first word, stall around bit 2 and on the last bit, rst+load.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rst             = vecs[i].rst;
         if_a.load_valid = vecs[i].lv;
         if_a.pin        = vecs[i].pin;
         if_a.shift_en   = vecs[i].se;
         #1;
         chk($sformatf("a[%0d] sout", i), 32'(if_a.sout), 32'(vecs[i].sout));
         chk($sformatf("a[%0d] sout_valid", i), 32'(if_a.sout_valid), 32'(vecs[i].sv));
         chk($sformatf("a[%0d] last", i), 32'(if_a.last), 32'(vecs[i].last));
         chk($sformatf("a[%0d] load_ready", i), 32'(if_a.load_ready), 32'(vecs[i].rdy));
         chk($sformatf("a[%0d] busy", i), 32'(if_a.busy), 32'(vecs[i].sv));
      end

      // LSB-first: 4'b1100 goes out 0,0,1,1; not ready until the last bit.
      @(negedge clk);
      if_b.load_valid = 1'b1; if_b.pin = wb; if_b.shift_en = 1'b1;
      #1 chk("b accept ready", 32'(if_b.load_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if_b.load_valid = 1'b0;
         #1;
         chk($sformatf("b bit%0d sout", k), 32'(if_b.sout), 32'(wb[k]));
         chk($sformatf("b bit%0d sout_valid", k), 32'(if_b.sout_valid), 32'd1);
         chk($sformatf("b bit%0d last", k), 32'(if_b.last), 32'(k == 3));
         chk($sformatf("b bit%0d load_ready", k), 32'(if_b.load_ready), 32'(k == 3));
      end
      @(negedge clk);
      #1 chk("b idle sout_valid", 32'(if_b.sout_valid), 32'd0);
      chk("b idle sout", 32'(if_b.sout), 32'd0);

      // Back-to-back: A5 then 3C, 16 contiguous valid bits.
      @(negedge clk);
      if_c.load_valid = 1'b1; if_c.pin = 8'hA5; if_c.shift_en = 1'b1;
      #1 chk("c accept ready", 32'(if_c.load_ready), 32'd1);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if_c.load_valid = (k < 8);
         if_c.pin        = 8'h3C;
         #1;
         chk($sformatf("c bit%0d sout", k), 32'(if_c.sout), 32'(b2b[15-k]));
         chk($sformatf("c bit%0d sout_valid", k), 32'(if_c.sout_valid), 32'd1);
         chk($sformatf("c bit%0d last", k), 32'(if_c.last), 32'(k == 7 || k == 15));
         chk($sformatf("c bit%0d load_ready", k), 32'(if_c.load_ready),
             32'(k == 7 || k == 15));
      end
      @(negedge clk);
      #1 chk("c after b2b sout_valid", 32'(if_c.sout_valid), 32'd0);

      // Mid-word reset on 8'hFF, then a clean 8'h81.
      @(negedge clk);
      if_c.load_valid = 1'b1; if_c.pin = 8'hFF;
      #1 chk("c ff ready", 32'(if_c.load_ready), 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if_c.load_valid = 1'b0;
         #1 chk($sformatf("c ff bit%0d sout", k), 32'(if_c.sout), 32'd1);
      end
      @(negedge clk);
      rst = 1'b1;
      #1 chk("c ready during rst", 32'(if_c.load_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      if_c.load_valid = 1'b1; if_c.pin = w81;
      #1;
      chk("c post-rst sout", 32'(if_c.sout), 32'd0);
      chk("c post-rst sout_valid", 32'(if_c.sout_valid), 32'd0);
      chk("c post-rst last", 32'(if_c.last), 32'd0);
      chk("c post-rst busy", 32'(if_c.busy), 32'd0);
      chk("c post-rst ready", 32'(if_c.load_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if_c.load_valid = 1'b0;
         #1;
         chk($sformatf("c 81 bit%0d sout", k), 32'(if_c.sout), 32'(w81[7-k]));
         chk($sformatf("c 81 bit%0d last", k), 32'(if_c.last), 32'(k == 7));
      end
      @(negedge clk);
      #1 chk("c 81 done sout_valid", 32'(if_c.sout_valid), 32'd0);

      // High idle level with no load.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("d idle%0d sout", k), 32'(if_d.sout), 32'd1);
         chk($sformatf("d idle%0d sout_valid", k), 32'(if_d.sout_valid), 32'd0);
         chk($sformatf("d idle%0d busy", k), 32'(if_d.busy), 32'd0);
         chk($sformatf("d idle%0d load_ready", k), 32'(if_d.load_ready), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
